imem_boot_ctrl: RTL and testbench

IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_boot_ctrl.sv | 139 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the IMEM boot controller.
//   imem_state_e : boot FSM state encoding, also exported on state_o
//   DEPTH        : default IMEM depth in words
//   ADDR_W       : default IMEM word-address width
package imem_pkg;

    localparam int DEPTH  = 131072;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } imem_state_e;

endpackage

// File: rtl/imem_boot_ctrl.sv
// IMEM boot controller: loads an instruction image into an external IMEM
// and checks it against a modular checksum. It releases the core from reset
// only when the checksum matches. While the core runs, it translates fetch
// byte addresses into IMEM word addresses and traps illegal fetches.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   ld_start/ld_len/ld_csum  start a load session of ld_len words, expected sum
//   ld_valid/ld_data         loader word stream, ld_ready = accept
//   mem_we/mem_waddr/wdata   IMEM write port
//   fetch_req/fetch_addr     core fetch (byte PC)
//   mem_raddr, fetch_valid   IMEM read address, fetch usable
//   core_rst_n               registered active-low core reset
//   done, err, state_o       status
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for ld_start
// LOAD  | accepting loader words, writing IMEM, accumulating the sum
// RUN   | image verified, core out of reset, fetches served
// ERR   | bad length, checksum mismatch or illegal fetch; await ld_start
module imem_boot_ctrl #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = imem_pkg::DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic [WIDTH-1:0]  ld_csum,
    input  logic              ld_valid,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              ld_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              fetch_req,
    input  logic [WIDTH-1:0]  fetch_addr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              fetch_valid,
    output logic              core_rst_n,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_o
);
    import imem_pkg::*;

    localparam logic [ADDR_W:0]  DEPTH_LEN  = (ADDR_W+1)'(DEPTH);
    localparam logic [WIDTH-3:0] DEPTH_WORD = (WIDTH-2)'(DEPTH);

    imem_state_e      state_q, state_d;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  len_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] csum_q;
    logic             core_rst_q;
    logic             done_q;

    logic             len_ok;
    logic             accept;
    logic             last_word;
    logic [WIDTH-1:0] sum_next;
    logic             fault;
    logic             start_take;
    logic             ready_raw;
    logic             fetch_ok_raw;

    assign len_ok     = (ld_len != '0) && (ld_len <= DEPTH_LEN);
    assign accept     = (state_q == LOAD) && ld_valid;
    assign last_word  = (cnt_q == len_q - 1'b1);
    assign sum_next   = sum_q + ld_data;
    assign fault      = fetch_req && (state_q == RUN) &&
                        ((fetch_addr[1:0] != 2'b00) || (fetch_addr[WIDTH-1:2] >= DEPTH_WORD));
    // ld_start is ignored mid-load, so a new session can only open outside LOAD
    assign start_take = ld_start && (state_q != LOAD) && len_ok;

    always_comb begin
        state_d      = state_q;
        ready_raw    = 1'b0;
        fetch_ok_raw = 1'b0;
        case (state_q)
            IDLE, ERR: begin
                if (ld_start) state_d = len_ok ? LOAD : ERR;
            end
            LOAD: begin
                ready_raw = 1'b1;
                if (accept && last_word)
                    state_d = (sum_next == csum_q) ? RUN : ERR;
            end
            RUN: begin
                fetch_ok_raw = fetch_req && !fault;
                // a reload request takes priority over a fetch fault
                if (ld_start)   state_d = len_ok ? LOAD : ERR;
                else if (fault) state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            sum_q      <= '0;
            csum_q     <= '0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_take) begin
                len_q  <= ld_len;
                csum_q <= ld_csum;
                cnt_q  <= '0;
                sum_q  <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                sum_q <= sum_next;
            end
            core_rst_q <= (state_d == RUN);
            done_q     <= (state_d == RUN) && (state_q != RUN);
        end
    end

    // Handshake and status outputs are forced low for the whole reset cycle,
    // including the cycle before the reset edge takes effect on the state.
    assign ld_ready    = ready_raw && rst_n;
    assign mem_we      = accept && rst_n;
    assign mem_waddr   = cnt_q[ADDR_W-1:0];
    assign mem_wdata   = ld_data;
    assign mem_raddr   = fetch_addr[ADDR_W+1:2];
    assign fetch_valid = fetch_ok_raw && rst_n;
    assign core_rst_n  = core_rst_q;
    assign done        = done_q && rst_n;
    assign err         = (state_q == ERR) && rst_n;
    assign state_o     = state_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 131072;
    localparam int ADDR_W = 17;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              ld_start;
    logic [ADDR_W:0]   ld_len;
    logic [WIDTH-1:0]  ld_csum;
    logic              ld_valid;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              fetch_req;
    logic [WIDTH-1:0]  fetch_addr;
    logic [ADDR_W-1:0] mem_raddr;
    logic              fetch_valid;
    logic              core_rst_n;
    logic              done;
    logic              err;
    logic [1:0]        state_o;

    imem_boot_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_len(ld_len), .ld_csum(ld_csum),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .mem_raddr(mem_raddr), .fetch_valid(fetch_valid),
        .core_rst_n(core_rst_n), .done(done), .err(err), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    wr_t sb_q[$];
    logic [ADDR_W-1:0] exp_addr;

    logic [WIDTH-1:0] img [4];
    logic [WIDTH-1:0] img_sum;
    logic [WIDTH-1:0] w3 [3];
    logic [WIDTH-1:0] w3_sum;
    int wr_base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every IMEM write must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_wr++;
            if (sb_q.size() == 0) begin
                chk("unexpected_we", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("waddr", 64'(mem_waddr), 64'(e.addr));
                chk("wdata", 64'(mem_wdata), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [ADDR_W:0] len, input logic [WIDTH-1:0] cs);
        ld_start = 1'b1;
        ld_len   = len;
        ld_csum  = cs;
        exp_addr = '0;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        ld_valid = 1'b1;
        ld_data  = d;
        sb_q.push_back(wr_t'{addr: exp_addr, data: d});
        exp_addr = exp_addr + 1'b1;
        @(negedge clk);
        chk("ld_ready_load", 64'(ld_ready), 64'd1);
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic load_img();
        for (int i = 0; i < 4; i++) send(img[i]);
    endtask

    initial begin
        img[0] = 32'h0000_0013;
        img[1] = 32'h0020_83B3;
        img[2] = 32'h4020_83B3;
        img[3] = 32'h0000_0013;
        img_sum = '0;
        for (int i = 0; i < 4; i++) img_sum = img_sum + img[i];
        w3[0] = 32'h1111_1111;
        w3[1] = 32'hF222_2222;
        w3[2] = 32'h3333_3333;
        w3_sum = '0;
        for (int i = 0; i < 3; i++) w3_sum = w3_sum + w3[i];

        rst_n = 1'b0; ld_start = 1'b0; ld_len = '0; ld_csum = '0;
        ld_valid = 1'b0; ld_data = '0; fetch_req = 1'b0; fetch_addr = '0;
        exp_addr = '0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd0);
        chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ld_ready", 64'(ld_ready), 64'd0);

        // good 4-word image
        start(18'd4, img_sum);
        chk("load_state", 64'(state_o), 64'd1);
        load_img();
        chk("run_state", 64'(state_o), 64'd2);
        chk("run_done", 64'(done), 64'd1);
        chk("run_core_rst_n", 64'(core_rst_n), 64'd1);
        chk("run_ld_ready", 64'(ld_ready), 64'd0);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("run_core_rst_n_2", 64'(core_rst_n), 64'd1);

        // fetches in RUN
        fetch_req = 1'b1; fetch_addr = 32'h8;
        @(negedge clk);
        chk("raddr_8", 64'(mem_raddr), 64'd2);
        chk("fvalid_8", 64'(fetch_valid), 64'd1);
        tick();
        chk("state_after_ok_fetch", 64'(state_o), 64'd2);
        fetch_addr = 32'h6;
        @(negedge clk);
        chk("fvalid_misaligned", 64'(fetch_valid), 64'd0);
        tick();
        fetch_req = 1'b0;
        chk("fault_err_state", 64'(state_o), 64'd3);
        chk("fault_err", 64'(err), 64'd1);
        chk("fault_core_rst_n", 64'(core_rst_n), 64'd0);

        // same image with a wrong checksum
        start(18'd4, 32'h0);
        chk("reload_from_err", 64'(state_o), 64'd1);
        load_img();
        chk("bad_csum_state", 64'(state_o), 64'd3);
        chk("bad_csum_err", 64'(err), 64'd1);
        chk("bad_csum_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("bad_csum_done", 64'(done), 64'd0);

        // out-of-range fetch
        start(18'd4, img_sum);
        load_img();
        chk("run_again", 64'(state_o), 64'd2);
        fetch_req = 1'b1; fetch_addr = 32'h0008_0000;
        @(negedge clk);
        chk("fvalid_oob", 64'(fetch_valid), 64'd0);
        tick();
        fetch_req = 1'b0;
        chk("oob_err_state", 64'(state_o), 64'd3);

        // illegal lengths, then a legal one
        start(18'd0, 32'h0);
        chk("len0_err", 64'(state_o), 64'd3);
        start(18'(DEPTH + 1), 32'h0);
        chk("len_over_err", 64'(state_o), 64'd3);
        start(18'd3, w3_sum);
        chk("len3_load", 64'(state_o), 64'd1);

        // ld_valid toggling every other cycle
        wr_base = n_wr;
        for (int i = 0; i < 6; i++) begin
            ld_valid = (i % 2 == 0);
            if (i % 2 == 0) begin
                ld_data = w3[i/2];
                sb_q.push_back(wr_t'{addr: exp_addr, data: w3[i/2]});
                exp_addr = exp_addr + 1'b1;
            end else begin
                ld_data = 32'hDEAD_BEEF;
            end
            if (i < 5) begin
                @(negedge clk);
                chk("ld_ready_toggle", 64'(ld_ready), 64'd1);
            end
            tick();
        end
        ld_valid = 1'b0;
        chk("toggle_writes", 64'(n_wr - wr_base), 64'd3);
        chk("toggle_run", 64'(state_o), 64'd2);

        // ld_start wins over a simultaneous fault in RUN
        fetch_req = 1'b1; fetch_addr = 32'h6;
        start(18'd4, img_sum);
        fetch_req = 1'b0;
        chk("reload_state", 64'(state_o), 64'd1);
        chk("reload_core_rst_n", 64'(core_rst_n), 64'd0);

        // ld_start in LOAD is ignored
        ld_start = 1'b1; ld_len = '0;
        tick();
        ld_start = 1'b0;
        chk("start_ignored_in_load", 64'(state_o), 64'd1);

        // reset after 2 of 4 words
        wr_base = n_wr;
        send(img[0]);
        send(img[1]);
        rst_n = 1'b0;
        ld_valid = 1'b1; ld_data = img[2];
        @(negedge clk);
        chk("we_in_reset", 64'(mem_we), 64'd0);
        chk("ready_in_reset", 64'(ld_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        chk("midload_rst_state", 64'(state_o), 64'd0);
        repeat (3) tick();
        ld_valid = 1'b0;
        chk("midload_writes", 64'(n_wr - wr_base), 64'd2);
        chk("idle_after_rst", 64'(state_o), 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
